board_frame_ctrl: RTL

Frame controller and RAM arbiter between the SPI board receiver and the display scanner. It takes the received character stream (already synchronised into `clk`) and writes it into a double-buffered 2×N×N byte board RAM. It shares the RAM's single port with display read requests and swaps front/back banks only on display vsync. It also reports the per-frame count of a tracked character and the error flags.

---
 rtl/board_frame_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/board_frame_ctrl.sv
// board_frame_ctrl: receives a character stream into the back bank of a
// double-buffered board RAM, arbitrates the single RAM port against display
// reads, and swaps banks on vsync once a complete frame has been written.
module board_frame_ctrl #(
    parameter int unsigned N        = 32,
    parameter logic [7:0]  CNT_CHAR = 8'd74,
    localparam int unsigned LN = $clog2(N),
    localparam int unsigned AW = 1 + 2 * LN
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_rx_cs,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_byte,
    input  logic          i_vsync,
    input  logic          i_disp_req,
    input  logic [LN-1:0] i_disp_row,
    input  logic [LN-1:0] i_disp_col,
    output logic          o_disp_ack,
    output logic [7:0]    o_disp_data,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [7:0]    o_ram_wdata,
    input  logic [7:0]    i_ram_rdata,
    output logic          o_front_bank,
    output logic [15:0]   o_char_count,
    output logic          o_frame_done,
    output logic [1:0]    o_err,
    input  logic          i_err_clr
);

    localparam int unsigned IW = 2 * LN;
    localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StPend} state_t;

    state_t          r_state;
    logic            r_cs_d1;
    logic [IW-1:0]   r_idx;
    logic [15:0]     r_run_cnt;
    logic            r_hold_vld;
    logic [AW-1:0]   r_hold_addr;
    logic [7:0]      r_hold_data;
    logic            r_front_bank;
    logic [15:0]     r_char_count;
    logic            r_frame_done;
    logic [1:0]      r_err;
    logic            r_rd_busy;
    logic            r_disp_ack;
    logic [7:0]      r_disp_data;

    logic            w_cs_rise;
    logic            w_start;
    logic            w_accept;
    logic            w_drop;
    logic            w_short;
    logic            w_swap;
    logic            w_is_cnt;
    logic [IW-1:0]   w_base_idx;
    logic [15:0]     w_base_cnt;
    logic            w_rd_issue;

    assign w_cs_rise  = i_rx_cs & ~r_cs_d1;
    assign w_start    = (r_state == StIdle) & w_cs_rise;
    // A byte is taken only while a transfer is open and the holding slot is free.
    assign w_accept   = i_rx_valid & ~r_hold_vld & (((r_state == StRecv) & i_rx_cs) | w_start);
    assign w_drop     = i_rx_valid & ~w_accept;
    assign w_short    = (r_state == StRecv) & ~i_rx_cs;
    assign w_swap     = (r_state == StPend) & i_vsync & ~r_hold_vld;
    assign w_is_cnt   = (i_rx_byte == CNT_CHAR);
    // A byte arriving together with the cs rise becomes byte 0 of the new frame.
    assign w_base_idx = w_start ? '0 : r_idx;
    assign w_base_cnt = w_start ? '0 : r_run_cnt;
    // The ack cycle still sees the old request held high, so it is excluded.
    assign w_rd_issue = i_disp_req & ~r_hold_vld & ~r_rd_busy & ~r_disp_ack;

    // Receive FSM with write holding register, bank swap and frame statistics.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_cs_d1      <= 1'b0;
            r_idx        <= '0;
            r_run_cnt    <= '0;
            r_hold_vld   <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_front_bank <= 1'b0;
            r_char_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_cs_d1      <= i_rx_cs;
            // The held write always issues in the next cycle, so it never lingers.
            r_hold_vld   <= w_accept;
            r_frame_done <= w_swap;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state   <= StRecv;
                        r_idx     <= '0;
                        r_run_cnt <= '0;
                    end
                end
                StRecv: begin
                    if (w_short) begin
                        r_state <= StIdle;
                    end
                end
                StPend: begin
                    if (w_swap) begin
                        r_state      <= StIdle;
                        r_front_bank <= ~r_front_bank;
                        r_char_count <= r_run_cnt;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_accept) begin
                r_hold_addr <= {~r_front_bank, w_base_idx};
                r_hold_data <= i_rx_byte;
                r_idx       <= w_base_idx + 1'b1;
                r_run_cnt   <= w_base_cnt + 16'(w_is_cnt);
                if (w_base_idx == LAST_IDX) begin
                    r_state <= StPend;
                end
            end
        end
    end

    // Display read pipeline: issue, then capture RAM data and ack.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_busy   <= 1'b0;
            r_disp_ack  <= 1'b0;
            r_disp_data <= '0;
        end else begin
            r_rd_busy  <= w_rd_issue;
            r_disp_ack <= r_rd_busy;
            if (r_rd_busy) begin
                r_disp_data <= i_ram_rdata;
            end
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~{2{i_err_clr}}) | {w_drop, w_short};
        end
    end

    // RAM port mux: pending write first, otherwise a display read.
    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (r_hold_vld) begin
            o_ram_en    = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = r_hold_addr;
            o_ram_wdata = r_hold_data;
        end else if (w_rd_issue) begin
            o_ram_en   = 1'b1;
            o_ram_addr = {r_front_bank, i_disp_row, i_disp_col};
        end
    end

    assign o_disp_ack   = r_disp_ack;
    assign o_disp_data  = r_disp_data;
    assign o_front_bank = r_front_bank;
    assign o_char_count = r_char_count;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;

endmodule
